// File: rtl/row_fetch_unit.sv
// Row fetch engine: reads one image row per pass from a fixed-latency RAM into a staging
// register, then hands it to an output register that the convolution consumer retires.
module row_fetch_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ROW_WIDTH   = 4,
  parameter int NUM_ROWS    = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int RAM_LATENCY = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  output logic                            ram_rd_en,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  input  logic [DATA_WIDTH-1:0]           ram_rd_data,
  input  logic                            shift_row_up,
  output logic [ROW_WIDTH*DATA_WIDTH-1:0] row_data,
  output logic                            row_shift_in_rdy,
  output logic                            busy,
  output logic                            load_done
);

  localparam int WIDX_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int LAT_W  = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam int ROWS_W = $clog2(NUM_ROWS + 1);

  localparam logic [WIDX_W-1:0]     LAST_WORD  = WIDX_W'(ROW_WIDTH - 1);
  localparam logic [LAT_W-1:0]      LAST_DRAIN = LAT_W'(RAM_LATENCY - 1);
  localparam logic [ROWS_W-1:0]     ROWS_LAST  = ROWS_W'(NUM_ROWS - 1);
  localparam logic [ROWS_W-1:0]     ROWS_TOTAL = ROWS_W'(NUM_ROWS);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(ROW_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_WAIT} state_t;
  typedef logic [ROW_WIDTH-1:0][DATA_WIDTH-1:0] row_t;

  state_t                  state_q, state_d;
  logic [WIDX_W-1:0]       word_q, word_d;
  logic [LAT_W-1:0]        drain_q, drain_d;
  logic [WIDX_W-1:0]       cap_q, cap_d;
  logic [RAM_LATENCY-1:0]  vld_q, vld_d;
  logic [RAM_LATENCY:0]    vld_ext;
  logic                    stage_full_q, stage_full_d;
  logic [ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
  logic [ROWS_W-1:0]       rows_fetched_q, rows_fetched_d;
  logic [ROWS_W-1:0]       rows_consumed_q, rows_consumed_d;
  logic                    ram_rd_en_q, ram_rd_en_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  row_t                    row_q, row_d;
  logic                    rdy_q, rdy_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  row_t                    stage_q;

  logic capture, transfer, accept;

  assign capture  = vld_q[RAM_LATENCY-1];
  assign transfer = stage_full_q && (!rdy_q || shift_row_up);
  assign accept   = shift_row_up && rdy_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d         = state_q;
    word_d          = word_q;
    drain_d         = drain_q;
    cap_d           = cap_q;
    stage_full_d    = stage_full_q;
    row_addr_d      = row_addr_q;
    rows_fetched_d  = rows_fetched_q;
    rows_consumed_d = rows_consumed_q;
    ram_rd_en_d     = 1'b0;
    ram_addr_d      = ram_addr_q;
    row_d           = row_q;
    rdy_d           = rdy_q;
    busy_d          = busy_q;
    done_d          = 1'b0;

    // Each strobe travels down the valid pipe and marks the cycle its data returns.
    vld_ext = {vld_q, ram_rd_en_q};
    vld_d   = vld_ext[RAM_LATENCY-1:0];

    if (capture) begin
      cap_d = (cap_q == LAST_WORD) ? '0 : cap_q + 1'b1;
      if (cap_q == LAST_WORD) stage_full_d = 1'b1;
    end

    if (transfer) begin
      row_d        = stage_q;
      rdy_d        = 1'b1;
      stage_full_d = 1'b0;
    end else if (accept) begin
      rdy_d = 1'b0;
    end

    if (accept) begin
      rows_consumed_d = rows_consumed_q + 1'b1;
      if (rows_consumed_q == ROWS_LAST) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          state_d         = S_FETCH;
          busy_d          = 1'b1;
          row_addr_d      = base_addr;
          rows_fetched_d  = ROWS_W'(1);
          rows_consumed_d = '0;
          word_d          = '0;
          cap_d           = '0;
          ram_rd_en_d     = 1'b1;
          ram_addr_d      = base_addr;
        end
      end
      S_FETCH: begin
        if (word_q == LAST_WORD) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          word_d      = word_q + 1'b1;
          ram_rd_en_d = 1'b1;
          ram_addr_d  = ram_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = S_WAIT;
        else                       drain_d = drain_q + 1'b1;
      end
      S_WAIT: begin
        if (transfer) begin
          if (rows_fetched_q < ROWS_TOTAL) begin
            state_d        = S_FETCH;
            rows_fetched_d = rows_fetched_q + 1'b1;
            row_addr_d     = row_addr_q + ROW_STRIDE;
            word_d         = '0;
            ram_rd_en_d    = 1'b1;
            ram_addr_d     = row_addr_q + ROW_STRIDE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      word_q          <= '0;
      drain_q         <= '0;
      cap_q           <= '0;
      vld_q           <= '0;
      stage_full_q    <= 1'b0;
      row_addr_q      <= '0;
      rows_fetched_q  <= '0;
      rows_consumed_q <= '0;
      ram_rd_en_q     <= 1'b0;
      ram_addr_q      <= '0;
      row_q           <= '0;
      rdy_q           <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      drain_q         <= drain_d;
      cap_q           <= cap_d;
      vld_q           <= vld_d;
      stage_full_q    <= stage_full_d;
      row_addr_q      <= row_addr_d;
      rows_fetched_q  <= rows_fetched_d;
      rows_consumed_q <= rows_consumed_d;
      ram_rd_en_q     <= ram_rd_en_d;
      ram_addr_q      <= ram_addr_d;
      row_q           <= row_d;
      rdy_q           <= rdy_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // NOTE: the staging storage is not reset; stage_full_q alone says whether it holds a row.
  always_ff @(posedge clock) begin
    if (capture && !reset) stage_q[cap_q] <= ram_rd_data;
  end

  assign ram_rd_en        = ram_rd_en_q;
  assign ram_addr         = ram_addr_q;
  assign row_data         = row_q;
  assign row_shift_in_rdy = rdy_q;
  assign busy             = busy_q;
  assign load_done        = done_q;

endmodule

// File: tb/tb_row_fetch_unit.sv
// Bench for row_fetch_unit: a timeline model of row fetch/present/consume checked every
// cycle, plus hand-computed expectations for the basic, wrap, reset and ignored-input cases.
module tb_row_fetch_unit;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int NR = 3;
  localparam int AW = 8;
  localparam int L  = 2;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data;
  logic          shift_row_up;
  logic [W*DW-1:0] row_data;
  logic          row_shift_in_rdy;
  logic          busy;
  logic          load_done;

  row_fetch_unit #(
    .DATA_WIDTH (DW),
    .ROW_WIDTH  (W),
    .NUM_ROWS   (NR),
    .ADDR_WIDTH (AW),
    .RAM_LATENCY(L)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .ram_rd_en       (ram_rd_en),
    .ram_addr        (ram_addr),
    .ram_rd_data     (ram_rd_data),
    .shift_row_up    (shift_row_up),
    .row_data        (row_data),
    .row_shift_in_rdy(row_shift_in_rdy),
    .busy            (busy),
    .load_done       (load_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM returning data = address, L cycles after the strobe; junk when not read.
  logic [DW-1:0] ram_pipe [L];
  always @(posedge clock) begin
    ram_pipe[0] <= ram_rd_en ? ram_addr : 8'hEE;
    for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_rd_data = ram_pipe[L-1];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] row_val(input logic [7:0] b, input int n);
    row_val = '0;
    for (int k = 0; k < W; k++) row_val[k*8 +: 8] = 8'(int'(b) + n*W + k);
  endfunction

  // Timeline model: row n's reads start at fs, it is staged at fs+W+L, and it moves to
  // the output when the output is free or being consumed in that same cycle.
  int          mc = 0;
  bit          m_fetch_valid = 0;
  int          m_fs = 0;
  int          m_frow = 0;
  int          m_consumed = 0;
  logic [7:0]  m_base = '0;
  logic        m_rd_en = 0, m_rdy = 0, m_busy = 0, m_done = 0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_row = '0;

  always @(negedge clock) begin : model
    bit staged, acc, xfer, n_rdy, n_busy, n_done, n_rd;
    logic [31:0] n_row;
    if (chk_en) begin
      check("model ram_rd_en", ram_rd_en, m_rd_en);
      check("model ram_addr", ram_addr, m_addr);
      check("model row_data", row_data, m_row);
      check("model row_shift_in_rdy", row_shift_in_rdy, m_rdy);
      check("model busy", busy, m_busy);
      check("model load_done", load_done, m_done);
    end
    if (reset) begin
      m_fetch_valid = 0; m_consumed = 0; m_frow = 0;
      m_rd_en = 0; m_addr = '0; m_row = '0; m_rdy = 0; m_busy = 0; m_done = 0;
    end else begin
      staged = m_fetch_valid && (mc >= m_fs + W + L);
      acc    = shift_row_up && m_rdy;
      xfer   = staged && (!m_rdy || shift_row_up);
      n_rdy  = m_rdy; n_row = m_row; n_busy = m_busy; n_done = 0;
      if (xfer) begin
        n_rdy = 1; n_row = row_val(m_base, m_frow);
        if (m_frow + 1 < NR) begin m_frow++; m_fs = mc + 1; end
        else m_fetch_valid = 0;
      end else if (acc) n_rdy = 0;
      if (acc) begin
        m_consumed++;
        if (m_consumed == NR) begin n_done = 1; n_busy = 0; end
      end
      if (start && !m_busy) begin
        n_busy = 1; m_base = base_addr; m_consumed = 0;
        m_frow = 0; m_fs = mc + 1; m_fetch_valid = 1;
      end
      n_rd = m_fetch_valid && (mc + 1 >= m_fs) && (mc + 1 < m_fs + W);
      if (n_rd) m_addr = 8'(int'(m_base) + m_frow*W + (mc + 1 - m_fs));
      m_rd_en = n_rd; m_rdy = n_rdy; m_row = n_row; m_busy = n_busy; m_done = n_done;
    end
    mc++;
  end

  // One bench cycle: drive just after the edge, return at the following falling edge.
  // shmode: 0 = no shift, 1 = force shift, 2 = shift whenever a row is presented.
  task automatic tick(input logic st, input logic rs, input int shmode);
    @(posedge clock); #1;
    start = st;
    reset = rs;
    shift_row_up = (shmode == 1) ? 1'b1 : (shmode == 2) ? row_shift_in_rdy : 1'b0;
    @(negedge clock);
  endtask

  task automatic finish_load(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick(1'b0, 1'b0, 2);
      if (load_done) seen = 1;
    end
    check({tag, " load_done reached"}, seen, 1'b1);
  endtask

  // Cycles 1..20 after a start at base 0x10 with no consumer activity.
  task automatic basic_row(input string tag);
    for (int c = 1; c <= 20; c++) begin
      tick(1'b0, 1'b0, 0);
      if (c >= 1 && c <= 4) begin
        check({tag, " rd_en row0"}, ram_rd_en, 1'b1);
        check({tag, " addr row0"}, ram_addr, 8'(8'h10 + c - 1));
      end
      if (c == 1) check({tag, " busy cycle1"}, busy, 1'b1);
      if (c == 7) check({tag, " rdy cycle7"}, row_shift_in_rdy, 1'b0);
      if (c == 8) begin
        check({tag, " rdy cycle8"}, row_shift_in_rdy, 1'b1);
        check({tag, " row0 data"}, row_data, 32'h13121110);
        check({tag, " row1 first addr"}, ram_addr, 8'h14);
      end
      if (c == 11) check({tag, " row1 last addr"}, ram_addr, 8'h17);
      if (c >= 12) check({tag, " idle rd_en"}, ram_rd_en, 1'b0);
      if (c == 20) check({tag, " row held"}, row_data, 32'h13121110);
    end
  endtask

  initial begin
    int dones, acc;
    reset = 1'b1; start = 1'b0; shift_row_up = 1'b0; base_addr = '0;
    repeat (3) tick(1'b0, 1'b1, 0);
    @(posedge clock); #1;
    reset = 1'b0; chk_en = 1'b1;
    @(negedge clock);
    check("reset ram_rd_en", ram_rd_en, 1'b0);
    check("reset ram_addr", ram_addr, 8'h00);
    check("reset row_data", row_data, 32'h0);
    check("reset rdy", row_shift_in_rdy, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset load_done", load_done, 1'b0);

    // Basic row with a stalled consumer, then drain the load.
    base_addr = 8'h10;
    tick(1'b1, 1'b0, 0);
    basic_row("basic");
    finish_load("basic");

    // Back-to-back consumption.
    tick(1'b0, 1'b0, 0);
    base_addr = 8'h10;
    tick(1'b1, 1'b0, 0);
    dones = 0;
    for (int c = 1; c <= 30; c++) begin
      tick(1'b0, 1'b0, 2);
      if (load_done) dones++;
      if (c == 8)  check("b2b row0", row_data, 32'h13121110);
      if (c == 15) check("b2b row1", row_data, 32'h17161514);
      if (c == 22) begin
        check("b2b row2", row_data, 32'h1B1A1918);
        check("b2b busy before done", busy, 1'b1);
      end
      if (c == 23) begin
        check("b2b load_done", load_done, 1'b1);
        check("b2b busy falls", busy, 1'b0);
      end
    end
    check("b2b load_done pulses", dones, 1);

    // Address wrap.
    base_addr = 8'hFC;
    tick(1'b1, 1'b0, 0);
    for (int c = 1; c <= 15; c++) begin
      tick(1'b0, 1'b0, 2);
      if (c == 8) begin
        check("wrap row0", row_data, 32'hFFFEFDFC);
        check("wrap row1 addr", ram_addr, 8'h00);
      end
      if (c == 15) check("wrap row1", row_data, 32'h03020100);
    end
    finish_load("wrap");

    // Reset mid-fetch, then a clean restart.
    base_addr = 8'h10;
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b1, 0);
    check("pre-reset addr", ram_addr, 8'h12);
    for (int c = 4; c <= 6; c++) begin
      tick((c == 6) ? 1'b1 : 1'b0, 1'b0, 0);
      check("rst rd_en", ram_rd_en, 1'b0);
      check("rst addr", ram_addr, 8'h00);
      check("rst row_data", row_data, 32'h0);
      check("rst rdy", row_shift_in_rdy, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst load_done", load_done, 1'b0);
    end
    basic_row("restart");
    finish_load("restart");

    // Ignored start while busy, ignored shift while nothing is presented.
    base_addr = 8'h40;
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    base_addr = 8'h80;
    tick(1'b1, 1'b0, 0);
    base_addr = 8'h40;
    tick(1'b0, 1'b0, 0);
    check("ignored start addr c3", ram_addr, 8'h42);
    tick(1'b0, 1'b0, 0);
    check("ignored start addr c4", ram_addr, 8'h43);
    acc = 0;
    tick(1'b0, 1'b0, 1);
    if (shift_row_up && row_shift_in_rdy) acc++;
    check("early shift not ready", row_shift_in_rdy, 1'b0);
    begin
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        tick(1'b0, 1'b0, 2);
        if (load_done) begin
          seen = 1;
          check("accepts at load_done", acc, 3);
        end
        if (shift_row_up && row_shift_in_rdy) acc++;
      end
      check("ignored load_done reached", seen, 1'b1);
    end
    tick(1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/row_fetch_unit.md
# row_fetch_unit

Upstream feeder for `convolution_fsm`. It reads one image row at a time from the input-image RAM and stages it in a double buffer: a staging register and an output register. It presents each completed row on `row_data` with `row_shift_in_rdy`, and it retires the row when `convolution_fsm` pulses `shift_row_up`. Staging lets the fetch of row n+1 overlap the convolution of row n.

## Interface
- `DATA_WIDTH`, 8: bits per pixel.
- `ROW_WIDTH`, 4: pixels per row; equals `RAM_SR_DEPTH` of the consumer.
- `NUM_ROWS`, 8: rows fetched per image.
- `ADDR_WIDTH`, 8: RAM address width.
- `RAM_LATENCY`, 2: read latency in cycles (≥1).

- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begins one image load; sampled only when idle.
- `base_addr`  in  ADDR_WIDTH  address of pixel 0 of row 0; latched on an accepted `start`.
- `ram_rd_en`  out  1  read strobe.
- `ram_addr`  out  ADDR_WIDTH  read address.
- `ram_rd_data`  in  DATA_WIDTH  read data, valid `RAM_LATENCY` cycles after the strobe.
- `shift_row_up`  in  1  consumer took the presented row.
- `row_data`  out  ROW_WIDTH*DATA_WIDTH  presented row; pixel k sits in bits [k*DATA_WIDTH +: DATA_WIDTH].
- `row_shift_in_rdy`  out  1  `row_data` is valid.
- `busy`  out  1  a load is in progress.
- `load_done`  out  1  one-cycle pulse after the last row is consumed.

## Operation
- The fetch FSM has four states:
  - IDLE: waits for `start`; on `start`, goes to FETCH.
  - FETCH: issues `ROW_WIDTH` reads; then goes to DRAIN.
  - DRAIN: waits `RAM_LATENCY` cycles for returns; then goes to WAIT.
  - WAIT: the staging register is full and the engine waits for it to be freed.
- FETCH issues one read per cycle at consecutive addresses, starting at `row_addr`.
- Row n starts at `base_addr + n*ROW_WIDTH`, computed modulo 2^ADDR_WIDTH. Addresses wrap silently.
- A return-valid shift pipeline of depth `RAM_LATENCY` tags each read. Returning word k is written into staging slot k.
- `stage_full` sets after the last word of a row is captured.
- **Transfer:** when `stage_full` && (!`row_shift_in_rdy` || `shift_row_up`), the staging register is copied to the output register.
  - `row_shift_in_rdy` = 1 on the next cycle.
  - `stage_full` is cleared.
  - If `rows_fetched` < `NUM_ROWS`, FETCH of the next row starts the next cycle; otherwise the FSM goes to IDLE.
- `shift_row_up` with no transfer pending clears `row_shift_in_rdy`. `shift_row_up` while `row_shift_in_rdy` = 0 is ignored.
- `rows_consumed` increments on each accepted `shift_row_up`.
  - When it reaches `NUM_ROWS`, `load_done` pulses in the next cycle and `busy` falls in that same cycle.
- `start` while `busy` is ignored.
- `reset` at any time, including mid-fetch, clears the following. RAM data already in flight is discarded and never written to staging.
  - FSM → IDLE.
  - All counters.
  - `stage_full`.
  - Return-valid pipeline.
  - Output register.

## Timing
- Reset values: `ram_rd_en`=0, `ram_addr`=0, `row_data`=0, `row_shift_in_rdy`=0, `busy`=0, `load_done`=0.
- Cycle 0 is the cycle in which `start` is sampled high.
  - `busy`=1 and the first `ram_rd_en` are both in cycle 1. All outputs are registered.
  - Reads run in cycles 1..W, where W = `ROW_WIDTH`.
  - Data arrives in cycles 1+L..W+L, where L = `RAM_LATENCY`.
  - `stage_full` = 1 in cycle W+L+1.
  - First `row_shift_in_rdy` is in cycle W+L+2; for W=4, L=2 this is cycle 8.
  - The next row's first read is also in cycle W+L+2.
- Unstalled row period is W+L+1 cycles.
- A consumer stall holds `row_data` stable. The fetch engine completes at most one row ahead, then waits in WAIT with `ram_rd_en`=0.
- **Simultaneous events:** `shift_row_up` in the same cycle as `stage_full` with `row_shift_in_rdy`=1 transfers the new row with no bubble, so `row_shift_in_rdy` stays 1.
- `load_done` and `busy` fall are registered: cycle c+1 after the final accepted `shift_row_up` in cycle c.

## Test plan
All scenarios use W=4, L=2, `NUM_ROWS`=3, and a RAM model returning data = address.
- **Basic row 0:** `base_addr`=0x10, `start` in cycle 0, `shift_row_up` never asserted.
  - `ram_rd_en` is high in cycles 1–4 with `ram_addr` 0x10–0x13.
  - `row_shift_in_rdy`=1 in cycle 8 with `row_data`=0x13121110.
  - Reads for row 1 (0x14–0x17) occur in cycles 8–11; the engine then idles with `ram_rd_en`=0 and `row_data` unchanged.
- **Back-to-back consumption:** `shift_row_up` pulses each cycle that `row_shift_in_rdy`=1.
  - Rows 0x13121110, 0x17161514, 0x1B1A1918 are presented at 7-cycle spacing.
  - `load_done` pulses once, one cycle after the third accept; `busy`=0 in that same cycle.
- **Address wrap:** `base_addr`=0xFC.
  - Row 1 is read from 0x00–0x03 and presented as 0x03020100.
- **Reset mid-fetch:** `reset` asserted in cycle 3, released in cycle 4.
  - In cycles 4–6 all outputs are 0, with no staging write from returns in flight.
  - A new `start` reproduces the basic-row timing exactly.
- **Ignored inputs:**
  - A `start` pulse while `busy` causes no address restart.
  - A `shift_row_up` while `row_shift_in_rdy`=0 leaves `rows_consumed` unchanged; `load_done` still occurs after exactly 3 accepts.
